// File: rtl/pe_noc_pkg.sv
// Shared definitions for the PE-side NoC endpoint: header field layout,
// derived widths and the TX/RX state encodings.
package pe_noc_pkg;

  // Header flit: destination in the low bits, body length above it.
  localparam int HdrDstLsb = 0;

  function automatic int hdr_len_lsb(input int addr_width);
    return addr_width;
  endfunction

  function automatic int len_w(input int data_width, input int addr_width);
    return data_width - addr_width;
  endfunction

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HEAD = 2'd1,
    TX_BODY = 2'd2
  } tx_state_e;

  typedef enum logic {
    RX_HDR  = 1'b0,
    RX_BODY = 1'b1
  } rx_state_e;

endpackage

// File: rtl/pe_noc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always visible
// on pop_data while empty is low. Depth must be a power of two.
module pe_noc_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    count;
  logic             do_push;
  logic             do_pop;

  // The extra count bit is set only when all Depth entries are occupied.
  assign full     = count[PtrW];
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrOne;
      if (do_pop)  rd_ptr <= rd_ptr + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/full come from the count,
  // so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pe_noc_endpoint.sv
// Tile-side NoC network interface: TX packetizes core messages into a header
// plus body flits, RX checks the header and buffers body flits for the core.
module pe_noc_endpoint
  import pe_noc_pkg::*;
#(
  parameter  int DataWidth = 8,
  parameter  int AddrWidth = 2,
  parameter  int ViChAddr  = 1,
  parameter  int RxDepth   = 4,
  localparam int LenW      = len_w(DataWidth, AddrWidth)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [AddrWidth-1:0] MyAddr,
  input  logic                 TxReq,
  input  logic [AddrWidth-1:0] TxDst,
  input  logic [LenW-1:0]      TxLen,
  input  logic [ViChAddr-1:0]  TxVc,
  output logic                 TxAck,
  output logic                 TxErr,
  input  logic [DataWidth-1:0] TxData,
  input  logic                 TxValid,
  output logic                 TxReady,
  output logic [DataWidth-1:0] OutpData,
  output logic                 OutpEn,
  input  logic                 OutpReady,
  output logic [ViChAddr-1:0]  OutpSel,
  input  logic [DataWidth-1:0] InpData,
  input  logic                 InpEn,
  output logic                 InpReady,
  input  logic [ViChAddr-1:0]  InpSel,
  output logic [DataWidth-1:0] RxData,
  output logic                 RxValid,
  output logic                 RxLast,
  output logic [ViChAddr-1:0]  RxVc,
  input  logic                 RxReady,
  output logic                 ProtoErr
);

  localparam int LenLsb = hdr_len_lsb(AddrWidth);
  localparam int FifoW  = 1 + ViChAddr + DataWidth;
  localparam logic [LenW-1:0] LenOne = LenW'(1);

  // ---------------------------------------------------------------- TX path
  tx_state_e            tx_state, tx_next;
  logic [AddrWidth-1:0] tx_dst;
  logic [LenW-1:0]      tx_len;
  logic [LenW-1:0]      tx_cnt;
  logic [ViChAddr-1:0]  tx_vc;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    tx_next  = tx_state;
    TxAck    = 1'b0;
    TxErr    = 1'b0;
    TxReady  = 1'b0;
    OutpEn   = 1'b0;
    OutpData = '0;
    OutpSel  = '0;
    unique case (tx_state)
      TX_IDLE: begin
        // Reset gating keeps the pulses quiet while Reset is held low.
        if (TxReq && Reset) begin
          if (TxLen != '0) begin
            TxAck   = 1'b1;
            tx_next = TX_HEAD;
          end else begin
            TxErr = 1'b1;
          end
        end
      end
      TX_HEAD: begin
        OutpEn   = 1'b1;
        OutpData = {tx_len, tx_dst};
        OutpSel  = tx_vc;
        if (OutpReady) tx_next = TX_BODY;
      end
      TX_BODY: begin
        OutpEn   = TxValid;
        OutpData = TxData;
        OutpSel  = tx_vc;
        TxReady  = OutpReady;
        if (TxValid && OutpReady && tx_cnt == LenOne) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tx_state <= TX_IDLE;
      tx_dst   <= '0;
      tx_len   <= '0;
      tx_vc    <= '0;
      tx_cnt   <= '0;
    end else begin
      tx_state <= tx_next;
      if (TxAck) begin
        tx_dst <= TxDst;
        tx_len <= TxLen;
        tx_vc  <= TxVc;
      end
      if (tx_state == TX_HEAD && OutpReady) begin
        tx_cnt <= tx_len;
      end else if (tx_state == TX_BODY && TxValid && OutpReady) begin
        tx_cnt <= tx_cnt - LenOne;
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  rx_state_e            rx_state, rx_next;
  logic [LenW-1:0]      rx_cnt;
  logic [ViChAddr-1:0]  rx_vc;
  logic [AddrWidth-1:0] hdr_dst;
  logic [LenW-1:0]      hdr_len;
  logic                 hdr_fire;
  logic                 body_fire;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FifoW-1:0]     fifo_in;
  logic [FifoW-1:0]     fifo_out;

  assign hdr_dst = InpData[HdrDstLsb +: AddrWidth];
  assign hdr_len = InpData[LenLsb +: LenW];

  always_comb begin
    rx_next   = rx_state;
    InpReady  = 1'b0;
    hdr_fire  = 1'b0;
    body_fire = 1'b0;
    unique case (rx_state)
      RX_HDR: begin
        InpReady = Reset;
        hdr_fire = InpEn && InpReady;
        // A zero-length header is dropped and the next flit is a header again.
        if (hdr_fire && hdr_len != '0) rx_next = RX_BODY;
      end
      RX_BODY: begin
        InpReady  = Reset && !fifo_full;
        body_fire = InpEn && InpReady;
        if (body_fire && rx_cnt == LenOne) rx_next = RX_HDR;
      end
      default: rx_next = RX_HDR;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rx_state <= RX_HDR;
      rx_cnt   <= '0;
      rx_vc    <= '0;
      ProtoErr <= 1'b0;
    end else begin
      rx_state <= rx_next;
      if (hdr_fire) begin
        if (hdr_len == '0 || hdr_dst != MyAddr) ProtoErr <= 1'b1;
        if (hdr_len != '0) begin
          rx_cnt <= hdr_len;
          rx_vc  <= InpSel;
        end
      end
      if (body_fire) begin
        rx_cnt <= rx_cnt - LenOne;
        if (InpSel != rx_vc) ProtoErr <= 1'b1;
      end
    end
  end

  // Body flits carry the packet's latched VC even if InpSel strays.
  assign fifo_in = {(rx_cnt == LenOne), rx_vc, InpData};

  pe_noc_sync_fifo #(
    .Width (FifoW),
    .Depth (RxDepth)
  ) u_rx_fifo (
    .clk       (Clk),
    .rst_n     (Reset),
    .push      (body_fire),
    .push_data (fifo_in),
    .pop       (RxReady),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign RxValid = !fifo_empty;
  assign RxLast  = fifo_out[FifoW-1];
  assign RxVc    = fifo_out[DataWidth +: ViChAddr];
  assign RxData  = fifo_out[DataWidth-1:0];

endmodule

// File: tb/tb_pe_noc_endpoint.sv
// Directed bench for pe_noc_endpoint: expected flits are queued as stimulus
// is driven and compared by negedge monitors on both output interfaces.
module tb_pe_noc_endpoint;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] MyAddr;
  logic       TxReq;
  logic [1:0] TxDst;
  logic [5:0] TxLen;
  logic [0:0] TxVc;
  logic       TxAck;
  logic       TxErr;
  logic [7:0] TxData;
  logic       TxValid;
  logic       TxReady;
  logic [7:0] OutpData;
  logic       OutpEn;
  logic       OutpReady;
  logic [0:0] OutpSel;
  logic [7:0] InpData;
  logic       InpEn;
  logic       InpReady;
  logic [0:0] InpSel;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxLast;
  logic [0:0] RxVc;
  logic       RxReady;
  logic       ProtoErr;

  int tests = 0;
  int fails = 0;

  logic [8:0] tx_exp [$];   // {sel, data}
  logic [9:0] rx_exp [$];   // {last, vc, data}
  logic [8:0] tx_e;
  logic [9:0] rx_e;

  always #5 Clk = ~Clk;

  pe_noc_endpoint dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .MyAddr    (MyAddr),
    .TxReq     (TxReq),
    .TxDst     (TxDst),
    .TxLen     (TxLen),
    .TxVc      (TxVc),
    .TxAck     (TxAck),
    .TxErr     (TxErr),
    .TxData    (TxData),
    .TxValid   (TxValid),
    .TxReady   (TxReady),
    .OutpData  (OutpData),
    .OutpEn    (OutpEn),
    .OutpReady (OutpReady),
    .OutpSel   (OutpSel),
    .InpData   (InpData),
    .InpEn     (InpEn),
    .InpReady  (InpReady),
    .InpSel    (InpSel),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .RxLast    (RxLast),
    .RxVc      (RxVc),
    .RxReady   (RxReady),
    .ProtoErr  (ProtoErr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transfers happen on the next rising edge; inputs are stable at negedge.
  always @(negedge Clk) begin
    if (Reset === 1'b1 && OutpEn === 1'b1 && OutpReady === 1'b1) begin
      if (tx_exp.size() == 0) begin
        check("tx_unexpected_flit", 32'(tx_exp.size()), 32'd1);
      end else begin
        tx_e = tx_exp.pop_front();
        check("tx_flit", 32'({OutpSel, OutpData}), 32'(tx_e));
      end
    end
    if (Reset === 1'b1 && RxValid === 1'b1 && RxReady === 1'b1) begin
      if (rx_exp.size() == 0) begin
        check("rx_unexpected_flit", 32'(rx_exp.size()), 32'd1);
      end else begin
        rx_e = rx_exp.pop_front();
        check("rx_flit", 32'({RxLast, RxVc, RxData}), 32'(rx_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    step();
    Reset = 1'b1;
  endtask

  task automatic tx_cmd(input logic [1:0] dst, input logic [5:0] len, input logic vc);
    TxReq = 1'b1;
    TxDst = dst;
    TxLen = len;
    TxVc  = vc;
    tx_exp.push_back({vc, len, dst});
    @(negedge Clk);
    check("tx_ack", 32'(TxAck), 32'd1);
    check("tx_err_quiet", 32'(TxErr), 32'd0);
    step();
    TxReq = 1'b0;
  endtask

  task automatic tx_flit(input logic [7:0] d, input logic vc);
    int n = 0;
    TxData  = d;
    TxValid = 1'b1;
    tx_exp.push_back({vc, d});
    @(negedge Clk);
    while (TxReady !== 1'b1 && n < 20) begin
      n++;
      @(negedge Clk);
    end
    check("tx_ready", 32'(TxReady), 32'd1);
    step();
    TxValid = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] d, input logic sel);
    int n = 0;
    InpData = d;
    InpSel  = sel;
    InpEn   = 1'b1;
    @(negedge Clk);
    while (InpReady !== 1'b1 && n < 20) begin
      n++;
      @(negedge Clk);
    end
    check("inp_ready", 32'(InpReady), 32'd1);
    step();
    InpEn = 1'b0;
  endtask

  task automatic rx_drain();
    int n = 0;
    @(negedge Clk);
    while (rx_exp.size() != 0 && n < 50) begin
      n++;
      @(negedge Clk);
    end
    check("rx_drain", 32'(rx_exp.size()), 32'd0);
    step();
  endtask

  initial begin
    Reset = 1'b0; MyAddr = 2'd0;
    TxReq = 1'b0; TxDst = '0; TxLen = '0; TxVc = '0; TxData = '0; TxValid = 1'b0;
    OutpReady = 1'b0; InpData = '0; InpEn = 1'b0; InpSel = '0; RxReady = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_inp_ready", 32'(InpReady), 32'd0);
    check("rst_outp_en", 32'(OutpEn), 32'd0);
    check("rst_rx_valid", 32'(RxValid), 32'd0);
    check("rst_proto_err", 32'(ProtoErr), 32'd0);
    step();
    Reset = 1'b1;
    @(negedge Clk);
    check("post_rst_inp_ready", 32'(InpReady), 32'd1);
    step();

    // TX basic: header 0x0B on cycle 1, A1/A2 on cycles 2-3, idle on cycle 4
    OutpReady = 1'b1;
    tx_cmd(2'd3, 6'd2, 1'b0);
    TxData = 8'hA1; TxValid = 1'b1;
    @(negedge Clk);
    check("tx_head_en", 32'(OutpEn), 32'd1);
    check("tx_head_data", 32'(OutpData), 32'h0B);
    check("tx_head_ready", 32'(TxReady), 32'd0);
    step();
    tx_flit(8'hA1, 1'b0);
    tx_flit(8'hA2, 1'b0);
    @(negedge Clk);
    check("tx_idle_en", 32'(OutpEn), 32'd0);
    check("tx_sb_empty", 32'(tx_exp.size()), 32'd0);
    step();

    // TX backpressure: header held for 3 cycles, body not consumed meanwhile
    OutpReady = 1'b0;
    tx_cmd(2'd3, 6'd2, 1'b0);
    TxData = 8'hA1; TxValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("bp_head_en", 32'(OutpEn), 32'd1);
      check("bp_head_data", 32'(OutpData), 32'h0B);
      check("bp_tx_ready", 32'(TxReady), 32'd0);
      step();
    end
    OutpReady = 1'b1;
    tx_flit(8'hA1, 1'b0);
    tx_flit(8'hA2, 1'b0);
    @(negedge Clk);
    check("bp_idle_en", 32'(OutpEn), 32'd0);
    check("bp_sb_empty", 32'(tx_exp.size()), 32'd0);
    step();

    // TX zero length
    TxReq = 1'b1; TxLen = 6'd0; TxDst = 2'd1;
    @(negedge Clk);
    check("zl_err", 32'(TxErr), 32'd1);
    check("zl_ack", 32'(TxAck), 32'd0);
    check("zl_en", 32'(OutpEn), 32'd0);
    step();
    TxReq = 1'b0;
    @(negedge Clk);
    check("zl_err_pulse", 32'(TxErr), 32'd0);
    check("zl_en_after", 32'(OutpEn), 32'd0);
    step();

    // RX full/backpressure: 5-flit packet into a 4-deep FIFO
    MyAddr = 2'd2; RxReady = 1'b0;
    rx_send(8'h16, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rx_exp.push_back({1'b0, 1'b0, 8'hB1 + 8'(i)});
      rx_send(8'hB1 + 8'(i), 1'b0);
    end
    rx_exp.push_back({1'b1, 1'b0, 8'hB5});
    InpData = 8'hB5; InpEn = 1'b1;
    @(negedge Clk);
    check("full_inp_ready", 32'(InpReady), 32'd0);
    check("full_rx_valid", 32'(RxValid), 32'd1);
    check("full_head_data", 32'(RxData), 32'hB1);
    step();
    RxReady = 1'b1;
    rx_send(8'hB5, 1'b0);
    rx_drain();
    @(negedge Clk);
    check("full_proto_err", 32'(ProtoErr), 32'd0);
    check("full_rx_empty", 32'(RxValid), 32'd0);
    step();

    // RX wrong destination: error flagged, body still delivered
    rx_send(8'h09, 1'b1);
    @(negedge Clk);
    check("dst_proto_err", 32'(ProtoErr), 32'd1);
    step();
    rx_exp.push_back({1'b0, 1'b1, 8'hC1});
    rx_exp.push_back({1'b1, 1'b1, 8'hC2});
    rx_send(8'hC1, 1'b1);
    rx_send(8'hC2, 1'b1);
    rx_drain();

    // RX zero-length header after reset
    do_reset();
    @(negedge Clk);
    check("rst_clears_err", 32'(ProtoErr), 32'd0);
    step();
    rx_send(8'h00, 1'b0);
    @(negedge Clk);
    check("zl_proto_err", 32'(ProtoErr), 32'd1);
    check("zl_rx_valid", 32'(RxValid), 32'd0);
    check("zl_stays_hdr", 32'(InpReady), 32'd1);
    step();

    // Reset mid-packet: TX in BODY with cnt=3, RX in BODY with one flit buffered
    do_reset();
    RxReady = 1'b0;
    tx_cmd(2'd1, 6'd5, 1'b1);
    tx_flit(8'hD1, 1'b1);
    tx_flit(8'hD2, 1'b1);
    rx_send(8'h16, 1'b0);
    rx_send(8'h33, 1'b0);
    @(negedge Clk);
    check("mid_rx_valid_pre", 32'(RxValid), 32'd1);
    #1;
    Reset = 1'b0;
    TxData = 8'hD3; TxValid = 1'b1;
    InpData = 8'h44; InpEn = 1'b1;
    #1;
    check("mid_outp_en", 32'(OutpEn), 32'd0);
    check("mid_inp_ready", 32'(InpReady), 32'd0);
    check("mid_rx_valid", 32'(RxValid), 32'd0);
    check("mid_tx_ready", 32'(TxReady), 32'd0);
    step();
    Reset = 1'b1; TxValid = 1'b0; InpEn = 1'b0;
    @(negedge Clk);
    check("rec_inp_ready", 32'(InpReady), 32'd1);
    check("rec_rx_valid", 32'(RxValid), 32'd0);
    check("rec_outp_en", 32'(OutpEn), 32'd0);
    check("rec_tx_sb", 32'(tx_exp.size()), 32'd0);
    step();

    // Fresh single-flit packets on both paths
    RxReady = 1'b1;
    tx_cmd(2'd2, 6'd1, 1'b0);
    tx_flit(8'hE1, 1'b0);
    @(negedge Clk);
    check("new_tx_idle", 32'(OutpEn), 32'd0);
    check("new_tx_sb", 32'(tx_exp.size()), 32'd0);
    step();
    rx_send(8'h06, 1'b0);
    rx_exp.push_back({1'b1, 1'b0, 8'hF1});
    rx_send(8'hF1, 1'b0);
    rx_drain();
    @(negedge Clk);
    check("new_proto_err", 32'(ProtoErr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
